// File: rtl/dmem_subword_if.sv
// Bus bundle between the MEM stage (master) and the sub-word data memory (slave).
// Optional store counter port present only when DMEM_STORE_COUNT_EN is defined.
interface dmem_subword_if
`ifdef DMEM_STORE_COUNT_EN
    #(parameter int COUNT_W = 16)
`endif
    ;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [1:0]  memwrite;
    logic [1:0]  memread;
    logic        load_unsigned;
    logic [31:0] readdata;
    logic        rvalid;
    logic        misalign;
`ifdef DMEM_STORE_COUNT_EN
    logic [COUNT_W-1:0] store_count;
`endif

    modport master (
        output adr, writedata, memwrite, memread, load_unsigned,
        input  readdata, rvalid, misalign
`ifdef DMEM_STORE_COUNT_EN
        , input store_count
`endif
    );

    modport slave (
        input  adr, writedata, memwrite, memread, load_unsigned,
        output readdata, rvalid, misalign
`ifdef DMEM_STORE_COUNT_EN
        , output store_count
`endif
    );
endinterface

// File: rtl/dmem_subword.sv
// Data-memory responder for the pipelined MIPS core: byte/half/word stores with
// per-lane enables, sign/zero-extended sub-word loads with 1-cycle registered
// latency, and sticky misaligned-access detection.
// Optional feature macro: DMEM_STORE_COUNT_EN adds a wrapping committed-store counter.
module dmem_subword #(
    parameter int ADDR_W  = 6,
    parameter int COUNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    dmem_subword_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem_r [0:DEPTH-1];
    logic [31:0]       readdata_r;
    logic              rvalid_r;
    logic              misalign_r;

    logic [ADDR_W-1:0] word_idx_s;
    logic [1:0]        lane_s;
    logic              store_req_s;
    logic              load_req_s;
    logic              store_misal_s;
    logic              load_misal_s;
    logic              store_ok_s;
    logic              load_ok_s;
    logic              misal_evt_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rd_word_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [31:0]       load_data_s;
    logic              unused_s;

    // Upper address bits wrap modulo the array size and are deliberately ignored.
    assign word_idx_s  = bus.adr[ADDR_W+1:2];
    assign lane_s      = bus.adr[1:0];
    assign store_req_s = (bus.memwrite != 2'b00);
    assign load_req_s  = (bus.memread != 2'b00);

    // Alignment check per access size; byte accesses can never be misaligned.
    always_comb begin
        store_misal_s = 1'b0;
        load_misal_s  = 1'b0;
        case (bus.memwrite)
            2'b10:   store_misal_s = bus.adr[0];
            2'b11:   store_misal_s = (bus.adr[1:0] != 2'b00);
            default: store_misal_s = 1'b0;
        endcase
        case (bus.memread)
            2'b10:   load_misal_s = bus.adr[0];
            2'b11:   load_misal_s = (bus.adr[1:0] != 2'b00);
            default: load_misal_s = 1'b0;
        endcase
    end

    // A store always wins over a simultaneous load; the load side is then ignored
    // entirely, including its alignment.
    assign store_ok_s  = store_req_s && !store_misal_s;
    assign load_ok_s   = !store_req_s && load_req_s && !load_misal_s;
    assign misal_evt_s = (store_req_s && store_misal_s) ||
                         (!store_req_s && load_req_s && load_misal_s);

    // Lane enables and right-justified store data replicated across lanes.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = bus.writedata;
        case (bus.memwrite)
            2'b01: begin
                be_s    = 4'b0001 << lane_s;
                wdata_s = {4{bus.writedata[7:0]}};
            end
            2'b10: begin
                if (bus.adr[1]) begin
                    be_s = 4'b1100;
                end else begin
                    be_s = 4'b0011;
                end
                wdata_s = {2{bus.writedata[15:0]}};
            end
            2'b11: begin
                be_s    = 4'b1111;
                wdata_s = bus.writedata;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = bus.writedata;
            end
        endcase
    end

    // RAM array: byte-lane writes committed at the edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_ok_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_r[word_idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
                end
            end
        end
    end

    assign rd_word_s = mem_r[word_idx_s];
    assign byte_s    = rd_word_s[{lane_s, 3'b000} +: 8];
    assign half_s    = rd_word_s[{bus.adr[1], 4'b0000} +: 16];

    // Lane selection and sign/zero extension of the combinational read.
    always_comb begin
        load_data_s = 32'h0000_0000;
        case (bus.memread)
            2'b01: begin
                if (bus.load_unsigned) begin
                    load_data_s = {24'h00_0000, byte_s};
                end else begin
                    load_data_s = {{24{byte_s[7]}}, byte_s};
                end
            end
            2'b10: begin
                if (bus.load_unsigned) begin
                    load_data_s = {16'h0000, half_s};
                end else begin
                    load_data_s = {{16{half_s[15]}}, half_s};
                end
            end
            2'b11:   load_data_s = rd_word_s;
            default: load_data_s = 32'h0000_0000;
        endcase
    end

    // Registered load result, one-cycle valid pulse and sticky misalign flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_r <= 32'h0000_0000;
            rvalid_r   <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            rvalid_r <= load_ok_s;
            if (load_ok_s) begin
                readdata_r <= load_data_s;
            end
            if (misal_evt_s) begin
                misalign_r <= 1'b1;
            end
        end
    end

    assign bus.readdata = readdata_r;
    assign bus.rvalid   = rvalid_r;
    assign bus.misalign = misalign_r;

`ifdef DMEM_STORE_COUNT_EN
    logic [COUNT_W-1:0] store_count_r;

    // Committed-store counter; wraps naturally at 2**COUNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_count_r <= '0;
        end else if (store_ok_s) begin
            store_count_r <= store_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.store_count = store_count_r;
    assign unused_s = ^bus.adr[31:ADDR_W+2];
`else
    assign unused_s = ^{bus.adr[31:ADDR_W+2], COUNT_W[0]};
`endif

endmodule

// File: tb/tb_dmem_subword.sv
// Directed self-checking bench for dmem_subword; load results are scoreboarded.
module tb_dmem_subword;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    logic [31:0] exp_q [$];

`ifdef DMEM_STORE_COUNT_EN
    dmem_subword_if #(.COUNT_W(2)) bus ();
`else
    dmem_subword_if bus ();
`endif

    dmem_subword #(.ADDR_W(6), .COUNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One bus cycle: drive, push expectation, clock, then check the valid pulse
    // and pop the scoreboard when a load result is due.
    task automatic step(input string tag, input logic [1:0] mw, input logic [1:0] mr,
                        input logic [31:0] a, input logic [31:0] wd, input logic lu,
                        input logic exp_v, input logic [31:0] exp_d);
        logic [31:0] e;
        bus.memwrite      = mw;
        bus.memread       = mr;
        bus.adr           = a;
        bus.writedata     = wd;
        bus.load_unsigned = lu;
        if (exp_v) exp_q.push_back(exp_d);
        @(posedge clk);
        #1;
        bus.memwrite = 2'b00;
        bus.memread  = 2'b00;
        chk({tag, ".rvalid"}, {31'd0, bus.rvalid}, {31'd0, exp_v});
        if (exp_v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".data"}, bus.readdata, e);
        end
    endtask

    initial begin
        compared          = 0;
        mismatched        = 0;
        reset             = 1'b1;
        bus.adr           = 32'd0;
        bus.writedata     = 32'd0;
        bus.memwrite      = 2'b00;
        bus.memread       = 2'b00;
        bus.load_unsigned = 1'b0;
        #12;
        chk("rst.readdata", bus.readdata, 32'h0);
        chk("rst.rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("rst.misalign", {31'd0, bus.misalign}, 32'd0);
`ifdef DMEM_STORE_COUNT_EN
        chk("rst.count", {30'd0, bus.store_count}, 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        step("sb80",  2'b01, 2'b00, 32'd80, 32'h0000_00FA, 1'b0, 1'b0, 32'h0);
        step("lb80",  2'b00, 2'b01, 32'd80, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFA);
        step("lbu80", 2'b00, 2'b01, 32'd80, 32'h0, 1'b1, 1'b1, 32'h0000_00FA);
        step("sh82",  2'b10, 2'b00, 32'd82, 32'h0000_8001, 1'b0, 1'b0, 32'h0);
        step("lh82",  2'b00, 2'b10, 32'd82, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001);
        step("lhu82", 2'b00, 2'b10, 32'd82, 32'h0, 1'b1, 1'b1, 32'h0000_8001);
        step("lw80",  2'b00, 2'b11, 32'd80, 32'h0, 1'b0, 1'b1, 32'h8001_00FA);
        chk("misalign.pre", {31'd0, bus.misalign}, 32'd0);

        step("sw81mis", 2'b11, 2'b00, 32'd81, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("misalign.set", {31'd0, bus.misalign}, 32'd1);
`ifdef DMEM_STORE_COUNT_EN
        chk("count.mis", {30'd0, bus.store_count}, 32'd2);
`endif
        step("lw80b", 2'b00, 2'b11, 32'd80, 32'h0, 1'b0, 1'b1, 32'h8001_00FA);
        chk("misalign.sticky", {31'd0, bus.misalign}, 32'd1);

        step("sw84",  2'b11, 2'b00, 32'd84, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        step("lw84",  2'b00, 2'b11, 32'd84, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        step("lb87",  2'b00, 2'b01, 32'd87, 32'h0, 1'b0, 1'b1, 32'h0000_0012);
        step("lb84",  2'b00, 2'b01, 32'd84, 32'h0, 1'b0, 1'b1, 32'h0000_0078);
        step("lh81mis", 2'b00, 2'b10, 32'd81, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mis.hold", bus.readdata, 32'h0000_0078);
        step("lwwrap", 2'b00, 2'b11, 32'h0000_0154, 32'h0, 1'b0, 1'b1, 32'h1234_5678);

        // Reset asserted while a load is in flight.
        bus.memread = 2'b11;
        bus.adr     = 32'd84;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("midrst.readdata", bus.readdata, 32'h0);
        chk("midrst.misalign", {31'd0, bus.misalign}, 32'd0);
        bus.memread = 2'b00;
        @(posedge clk);
        #1;
        chk("midrst.rvalid2", {31'd0, bus.rvalid}, 32'd0);
        reset = 1'b0;
        step("lw84post", 2'b00, 2'b11, 32'd84, 32'h0, 1'b0, 1'b1, 32'h1234_5678);

        step("swlw88", 2'b11, 2'b11, 32'd88, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_STORE_COUNT_EN
        chk("count.1", {30'd0, bus.store_count}, 32'd1);
`endif
        step("lw88", 2'b00, 2'b11, 32'd88, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5);
        chk("both.nomis", {31'd0, bus.misalign}, 32'd0);
        step("sh89mis", 2'b10, 2'b00, 32'd89, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_STORE_COUNT_EN
        chk("count.mis2", {30'd0, bus.store_count}, 32'd1);
`endif
        step("sb92", 2'b01, 2'b00, 32'd92, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_STORE_COUNT_EN
        chk("count.2", {30'd0, bus.store_count}, 32'd2);
`endif
        step("sb93", 2'b01, 2'b00, 32'd93, 32'h0000_0022, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_STORE_COUNT_EN
        chk("count.3", {30'd0, bus.store_count}, 32'd3);
`endif
        step("sb94", 2'b01, 2'b00, 32'd94, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_STORE_COUNT_EN
        chk("count.0", {30'd0, bus.store_count}, 32'd0);
`endif
        step("sb95", 2'b01, 2'b00, 32'd95, 32'h0000_0044, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_STORE_COUNT_EN
        chk("count.1b", {30'd0, bus.store_count}, 32'd1);
`endif
        step("lw92",  2'b00, 2'b11, 32'd92, 32'h0, 1'b0, 1'b1, 32'h4433_2211);
        step("lh94",  2'b00, 2'b10, 32'd94, 32'h0, 1'b0, 1'b1, 32'h0000_4433);
        step("lw88b", 2'b00, 2'b11, 32'd88, 32'h0, 1'b1, 1'b1, 32'hA5A5_A5A5);
        step("idle",  2'b00, 2'b00, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("idle.hold", bus.readdata, 32'hA5A5_A5A5);
        chk("sb.empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_subword.md
Name: dmem_subword

Overview:
- Data-memory responder for the pipelined MIPS core: the memory side of the byte/half/word store interface the core drives, plus sign- or zero-extended sub-word loads (lb/lbu/lh/lhu/lw).
- Sits between the MEM stage and the data RAM array.
- Stores are committed synchronously with per-lane byte enables.
- Loads are returned with a fixed 1-cycle registered latency.
- Misaligned accesses are detected, suppressed and flagged.

Parameters:
- ADDR_W, 6, word-address width; array depth = 2**ADDR_W 32-bit words.
- COUNT_W, 16, width of committed-store counter (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- adr  input  32  byte address from the MEM stage.
- writedata  input  32  store data; sub-word data is right-justified.
- memwrite  input  2  store size: 00 none, 01 byte, 10 half, 11 word.
- memread  input  2  load size: 00 none, 01 byte, 10 half, 11 word.
- load_unsigned  input  1  1 = zero-extend sub-word load, 0 = sign-extend.
- readdata  output  32  extended load result, registered.
- rvalid  output  1  readdata valid this cycle (1-cycle pulse per load).
- misalign  output  1  sticky misaligned-access flag.
- store_count  output  COUNT_W  committed stores (only with STORE_COUNT_EN).

Behaviour:
- Reset (async, active-high) state:
  - readdata=0, rvalid=0, misalign=0, store_count=0.
  - RAM contents are not cleared.
- Addressing:
  - Word index = adr[ADDR_W+1:2].
  - Upper address bits are ignored (wrap modulo array size).
  - Lanes are little-endian: lane k = bits 8k+7:8k, with k = adr[1:0].
- Alignment:
  - Byte accesses are always aligned.
  - Half accesses require adr[0]=0.
  - Word accesses require adr[1:0]=00.
- Store (memwrite!=00, aligned):
  - Committed at the rising edge of the same cycle.
  - Byte: writedata[7:0] goes to lane adr[1:0].
  - Half: writedata[15:0] goes to lanes {adr[1],1}:{adr[1],0}.
  - Word: all 4 lanes are written.
  - Unselected lanes are unchanged.
- Load (memread!=00, aligned):
  - RAM is read combinationally in cycle N.
  - The lane is selected and extended, then registered into readdata at the edge ending cycle N.
  - rvalid=1 during cycle N+1.
  - readdata holds its value until the next load; rvalid returns to 0 if no load is issued.
- Extension:
  - Byte: bit 7 is replicated into bits 31:8 when load_unsigned=0, else zeros.
  - Half: same rule using bit 15.
  - Word: load_unsigned is ignored.
- Load-after-store: a load in cycle N+1 to a word stored in cycle N returns the new data (the write is already committed).
- Misaligned access:
  - A misaligned store is not written, and store_count does not increment.
  - A misaligned load gives no readdata update and rvalid stays 0.
  - Either case sets misalign=1; it clears only on reset.
- Simultaneous memwrite!=00 and memread!=00 (illegal from the core):
  - The store is performed and the load is ignored (rvalid=0).
  - misalign is unaffected.
- Reset mid-load: rvalid is forced to 0 asynchronously; a pending result is discarded.

Optional Feature:
- Macro DMEM_STORE_COUNT_EN.
- When defined:
  - Port store_count exists.
  - It increments by 1 on every committed (aligned) store.
  - It wraps from 2**COUNT_W-1 to 0.
  - It is cleared on reset.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Byte store/load: reset, then sb 0x000000FA at adr 80, then lb 80 -> next cycle rvalid=1, readdata=0xFFFFFFFA. Follow with lbu 80 -> readdata=0x000000FA.
- Half store and lane merge: with word 80 = 0x000000FA, sh 0x00008001 at adr 82. Then lh 82 -> readdata=0xFFFF8001; lhu 82 -> 0x00008001; lw 80 -> 0x800100FA.
- Misaligned store: sw 0xDEADBEEF at adr 81 -> word 80 unchanged (lw 80 still 0x800100FA), misalign=1 and stays 1. With DMEM_STORE_COUNT_EN, store_count unchanged.
- Load-after-store: sw 0x12345678 at adr 84 in cycle N, lw 84 in cycle N+1 -> readdata=0x12345678 in cycle N+2. Then lb 87 -> 0x00000012; lb 84 -> 0x00000078.
- Reset mid-load: issue lw 84, assert reset before the next edge -> rvalid=0, readdata=0, misalign=0. Then lw 84 after reset -> 0x12345678 (RAM retained).
- Counter wrap (DMEM_STORE_COUNT_EN, COUNT_W=2): 5 aligned stores -> store_count sequence 1,2,3,0,1. A simultaneous store+load cycle counts the store and gives rvalid=0.
